bram_byte_reader: RTL and testbench

Streaming read controller for the 8-bit BRAM in the CDC VGA AXI slave pcore. On a start command it walks a byte-address range through the BRAM's registered read port and presents the bytes on a valid/ready stream with full backpressure. It compensates for the BRAM's one-cycle read latency with a 2-entry output buffer, so no byte is lost or duplicated. It is the consumer end of the memory's write/read pair.

---
 rtl/bram_byte_reader.sv | 136 +++++++++++++
 tb/tb_bram_byte_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_byte_reader.sv
// Streams a byte-address range out of a registered-read BRAM onto a
// valid/ready port, hiding the one-cycle read latency with a 2-entry skid buffer.
module bram_byte_reader #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEMORY_SIZE      = 512,
  parameter int C_LEN_WIDTH        = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          start,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] start_addr,
  input  logic [C_LEN_WIDTH-1:0]        length,
  output logic                          busy,
  output logic                          done,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] raddr,
  input  logic [7:0]                    read_data,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last
);

  localparam int STRIDE = C_S_AXI_ADDR_WIDTH / 8;

  if (C_MEMORY_SIZE < 1 || STRIDE < 1) begin : g_bad_params
    $error("bram_byte_reader: invalid memory size or address width");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [C_LEN_WIDTH-1:0]   remaining;
  logic                     inflight;
  logic                     inflight_last;
  logic [1:0]               occ;
  logic [7:0]               d0;
  logic [7:0]               d1;
  logic                     l0;
  logic                     l1;

  logic                     accept;
  logic                     pop;
  logic                     issue;
  logic                     last_pop;
  logic [2:0]               fill;

  assign m_data  = d0;
  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid & l0;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept && length != '0)         state_d = RUN;
      RUN:   if (issue && remaining == C_LEN_WIDTH'(1)) state_d = DRAIN;
      DRAIN: if (last_pop)                       state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  // Issue decision sees m_ready combinationally so a pop frees a slot at once.
  always_comb begin
    accept   = (state_q == IDLE) && start;
    pop      = m_valid && m_ready;
    last_pop = pop && l0;
    fill     = {1'b0, occ} + {2'b00, inflight};
    issue    = (state_q == RUN) && (remaining != '0) &&
               ((fill < 3'd2) || pop);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      raddr         <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= 2'd0;
      d0            <= 8'h00;
      d1            <= 8'h00;
      l0            <= 1'b0;
      l1            <= 1'b0;
    end else begin
      busy          <= (state_d != IDLE);
      done          <= (accept && length == '0) ||
                       (state_q == DRAIN && last_pop);
      inflight      <= issue;
      inflight_last <= issue && (remaining == C_LEN_WIDTH'(1));
      if (accept && length != '0) begin
        raddr     <= start_addr;
        remaining <= length;
      end else if (issue) begin
        raddr     <= raddr + C_S_AXI_ADDR_WIDTH'(STRIDE);
        remaining <= remaining - C_LEN_WIDTH'(1);
      end
      unique case ({inflight, pop})
        2'b10: begin
          occ <= occ + 2'd1;
          if (occ == 2'd0) begin
            d0 <= read_data;
            l0 <= inflight_last;
          end else begin
            d1 <= read_data;
            l1 <= inflight_last;
          end
        end
        2'b01: begin
          occ <= occ - 2'd1;
          d0  <= d1;
          l0  <= l1;
          l1  <= 1'b0;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            d0 <= read_data;
            l0 <= inflight_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= read_data;
            l1 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_byte_reader.sv
// Directed bench for bram_byte_reader with a behavioural 512x8 BRAM.
// Expected streams are hand-built byte lists.
module tb_bram_byte_reader;

  typedef logic [7:0] bq_t[$];

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] length = '0;
  logic        busy;
  logic        done;
  logic [31:0] raddr;
  logic [7:0]  read_data = 8'h00;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;

  logic [7:0]  mem [0:511];
  int          compared = 0;
  int          mismatched = 0;

  bram_byte_reader dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .read_data  (read_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) read_data <= mem[raddr[10:2]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Runs one transfer; optional checks for timing, raddr hold and a
  // start pulse injected while busy.
  task automatic run_xfer(input string name, input logic [31:0] addr,
                          input int len, input bq_t exp,
                          input logic [63:0] rdy, input int exp_first,
                          input int exp_done, input bit chk_hold,
                          input int poke);
    int c;
    int cnt;
    int first;
    bit seen_done;
    bit stall;
    logic [7:0] held;
    c = 0;
    cnt = 0;
    first = -1;
    seen_done = 0;
    stall = 0;
    held = 8'h00;
    start = 1'b1;
    start_addr = addr;
    length = 16'(len);
    m_ready = rdy[0];
    @(negedge ACLK);
    tick();
    c = 1;
    while (!seen_done && c < 200) begin
      start = (c == poke);
      start_addr = (c == poke) ? 32'h100 : addr;
      length = (c == poke) ? 16'd9 : 16'(len);
      m_ready = rdy[c % 64];
      @(negedge ACLK);
      if (c == 1) chk({name, " raddr_c1"}, raddr, addr);
      if (c == 1) chk({name, " busy_c1"}, {31'b0, busy}, 1);
      if (chk_hold && (c == 4 || c == 15))
        chk({name, " raddr_hold"}, raddr, addr + 32'd8);
      if (stall) begin
        chk({name, " stall_valid"}, {31'b0, m_valid}, 1);
        chk({name, " stall_data"}, {24'b0, m_data}, {24'b0, held});
      end
      stall = m_valid && !m_ready;
      held = m_data;
      if (m_valid && m_ready) begin
        if (first < 0) first = c;
        if (cnt < len) begin
          chk({name, " data"}, {24'b0, m_data}, {24'b0, exp[cnt]});
          chk({name, " last"}, {31'b0, m_last}, {31'b0, cnt == len - 1});
        end
        cnt++;
      end
      if (done) begin
        seen_done = 1;
        chk({name, " count"}, cnt, len);
        chk({name, " busy_at_done"}, {31'b0, busy}, 0);
        if (exp_done > 0) chk({name, " done_cycle"}, c, exp_done);
        if (exp_first > 0) chk({name, " first_cycle"}, first, exp_first);
      end
      tick();
      c++;
    end
    if (!seen_done) chk({name, " timeout"}, 0, 1);
    start = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    bq_t e;
    for (int i = 0; i < 512; i++) mem[i] = 8'(8'h10 + i);

    tick();
    @(negedge ACLK);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    chk("rst m_valid", {31'b0, m_valid}, 0);
    chk("rst m_last", {31'b0, m_last}, 0);
    chk("rst m_data", {24'b0, m_data}, 0);
    chk("rst raddr", raddr, 0);
    tick();
    ARESETN = 1'b1;
    tick();

    e = '{8'h10, 8'h11, 8'h12, 8'h13};
    run_xfer("basic", 32'h0, 4, e, '1, 3, 7, 0, -1);

    e = {};
    for (int i = 0; i < 16; i++) e.push_back(8'(8'h10 + i));
    run_xfer("random_rdy", 32'h0, 16, e, 64'hA5C3_96E1_3C5A_F00F,
             0, 0, 0, -1);

    e = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    run_xfer("backpressure", 32'h10, 8, e, 64'hFFFF_FFFF_FFFF_0000,
             0, 0, 1, -1);

    start = 1'b1;
    start_addr = 32'h40;
    length = 16'd0;
    tick();
    start = 1'b0;
    @(negedge ACLK);
    chk("len0 done_c1", {31'b0, done}, 1);
    chk("len0 busy_c1", {31'b0, busy}, 0);
    chk("len0 valid_c1", {31'b0, m_valid}, 0);
    tick();
    @(negedge ACLK);
    chk("len0 done_c2", {31'b0, done}, 0);
    chk("len0 valid_c2", {31'b0, m_valid}, 0);
    tick();

    e = '{8'h18, 8'h19, 8'h1A, 8'h1B};
    run_xfer("start_busy", 32'h20, 4, e, '1, 3, 7, 0, 2);

    mem[511] = 8'hAA;
    mem[0] = 8'hBB;
    mem[1] = 8'hCC;
    e = '{8'hAA, 8'hBB, 8'hCC};
    run_xfer("wrap", 32'h7FC, 3, e, '1, 3, 6, 0, -1);

    start = 1'b1;
    start_addr = 32'h0;
    length = 16'd8;
    m_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    ARESETN = 1'b0;
    tick();
    @(negedge ACLK);
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst done", {31'b0, done}, 0);
    chk("midrst m_valid", {31'b0, m_valid}, 0);
    chk("midrst m_last", {31'b0, m_last}, 0);
    chk("midrst m_data", {24'b0, m_data}, 0);
    chk("midrst raddr", raddr, 0);
    tick();
    ARESETN = 1'b1;
    m_ready = 1'b0;
    tick();
    @(negedge ACLK);
    chk("postrst m_valid", {31'b0, m_valid}, 0);
    tick();
    e = '{8'h18, 8'h19};
    run_xfer("after_rst", 32'h20, 2, e, '1, 3, 5, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
